// File: rtl/commit_unit_pkg.sv
// Shared widths, op codes, memory size encoding and FSM states for the retire stage.
package commit_unit_pkg;

    localparam int ROB_ID_WIDTH    = 5;
    localparam int ALU_OP_WIDTH    = 8;
    localparam int REG_ADDR_WIDTH  = 5;
    localparam int REG_WIDTH       = 32;
    localparam int INST_ADDR_WIDTH = 32;

    localparam logic [ALU_OP_WIDTH-1:0] OP_NOP  = 8'h00;
    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = 8'h01;
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = 8'h02;
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = 8'h03;
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = 8'h04;
    localparam logic [ALU_OP_WIDTH-1:0] OP_LW   = 8'h10;
    localparam logic [ALU_OP_WIDTH-1:0] OP_BEQ  = 8'h20;
    localparam logic [ALU_OP_WIDTH-1:0] OP_BNE  = 8'h21;
    localparam logic [ALU_OP_WIDTH-1:0] OP_BLT  = 8'h22;
    localparam logic [ALU_OP_WIDTH-1:0] OP_BGE  = 8'h23;
    localparam logic [ALU_OP_WIDTH-1:0] OP_BLTU = 8'h24;
    localparam logic [ALU_OP_WIDTH-1:0] OP_BGEU = 8'h25;
    localparam logic [ALU_OP_WIDTH-1:0] OP_JAL  = 8'h30;
    localparam logic [ALU_OP_WIDTH-1:0] OP_JALR = 8'h31;
    localparam logic [ALU_OP_WIDTH-1:0] OP_SB   = 8'h40;
    localparam logic [ALU_OP_WIDTH-1:0] OP_SH   = 8'h41;
    localparam logic [ALU_OP_WIDTH-1:0] OP_SW   = 8'h42;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STORE,
        S_FLUSH
    } commit_state_t;

    function automatic logic [1:0] store_size(input logic [ALU_OP_WIDTH-1:0] op);
        case (op)
            OP_SB:   return MEM_SIZE_B;
            OP_SH:   return MEM_SIZE_H;
            default: return MEM_SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/commit_mispredict_check.sv
// Classifies the ROB head op and decides whether its control flow was mispredicted.
module commit_mispredict_check
    import commit_unit_pkg::*;
(
    input  logic [ALU_OP_WIDTH-1:0]    op,
    input  logic                       pred,
    input  logic                       outcome,
    input  logic [INST_ADDR_WIDTH-1:0] pred_target,
    input  logic [INST_ADDR_WIDTH-1:0] addr,
    input  logic [INST_ADDR_WIDTH-1:0] pc,
    output logic                       is_branch,
    output logic                       is_jump,
    output logic                       is_store,
    output logic                       mispredict,
    output logic [INST_ADDR_WIDTH-1:0] redirect_pc
);

    always_comb begin
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_store  = 1'b0;
        case (op)
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: is_branch = 1'b1;
            OP_JAL, OP_JALR:                                  is_jump   = 1'b1;
            OP_SB, OP_SH, OP_SW:                              is_store  = 1'b1;
            default: ;
        endcase
    end

    // A taken branch can still be wrong if the predicted target differs.
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = pc + 32'd4;
        if (is_branch) begin
            mispredict = (outcome != pred) || (outcome && pred && (pred_target != addr));
            if (outcome) redirect_pc = addr;
        end else if (is_jump) begin
            mispredict  = !pred || (pred_target != addr);
            redirect_pc = addr;
        end
    end

endmodule

// File: rtl/commit_unit.sv
// In-order retire stage: acknowledges the ROB head, writes the register file,
// performs committed stores and raises a one-cycle flush on mispredicts.
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       head_valid,
    input  logic [ROB_ID_WIDTH-1:0]    head_id,
    input  logic [ALU_OP_WIDTH-1:0]    head_op,
    input  logic [REG_ADDR_WIDTH-1:0]  head_rd,
    input  logic [REG_WIDTH-1:0]       head_value,
    input  logic [INST_ADDR_WIDTH-1:0] head_pc,
    input  logic [INST_ADDR_WIDTH-1:0] head_addr,
    input  logic                       head_pred,
    input  logic                       head_outcome,
    input  logic [INST_ADDR_WIDTH-1:0] head_pred_target,
    output logic                       commit_ack,
    output logic                       rf_we,
    output logic [REG_ADDR_WIDTH-1:0]  rf_waddr,
    output logic [REG_WIDTH-1:0]       rf_wdata,
    output logic [ROB_ID_WIDTH-1:0]    rf_wrob_id,
    output logic                       mem_req,
    output logic [INST_ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]       mem_wdata,
    output logic [1:0]                 mem_size,
    input  logic                       mem_done,
    output logic                       flush,
    output logic [INST_ADDR_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]       commit_cnt,
    output logic [CNT_WIDTH-1:0]       mispred_cnt
);

    commit_state_t state, next_state;

    logic                       is_branch, is_jump, is_store, mispredict;
    logic [INST_ADDR_WIDTH-1:0] check_redirect;
    logic                       idle_commit, store_start, do_flush;

    commit_mispredict_check u_check (
        .op          (head_op),
        .pred        (head_pred),
        .outcome     (head_outcome),
        .pred_target (head_pred_target),
        .addr        (head_addr),
        .pc          (head_pc),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .is_store    (is_store),
        .mispredict  (mispredict),
        .redirect_pc (check_redirect)
    );

    assign idle_commit = (state == S_IDLE) && head_valid && !is_store;
    assign store_start = (state == S_IDLE) && head_valid && is_store;
    assign do_flush    = idle_commit && mispredict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        commit_ack = 1'b0;
        case (state)
            S_IDLE: begin
                if (head_valid) begin
                    if (is_store) begin
                        next_state = S_STORE;
                    end else begin
                        commit_ack = 1'b1;
                        next_state = mispredict ? S_FLUSH : S_IDLE;
                    end
                end
            end
            S_STORE: begin
                if (mem_done) begin
                    commit_ack = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_FLUSH: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Jumps write their link register even when they mispredict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_wrob_id <= '0;
        end else begin
            rf_we <= idle_commit && !is_branch && (head_rd != '0);
            if (idle_commit && !is_branch && (head_rd != '0)) begin
                rf_waddr   <= head_rd;
                rf_wdata   <= head_value;
                rf_wrob_id <= head_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_size  <= MEM_SIZE_B;
        end else if (store_start) begin
            mem_req   <= 1'b1;
            mem_addr  <= head_addr;
            mem_wdata <= head_value;
            mem_size  <= store_size(head_op);
        end else if ((state == S_STORE) && mem_done) begin
            mem_req <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush <= do_flush;
            if (do_flush) redirect_pc <= check_redirect;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (commit_ack && (commit_cnt != '1))
                commit_cnt <= commit_cnt + CNT_WIDTH'(1);
            if (do_flush && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
